llsc_monitor: RTL

Parametrised multi-channel load-linked/store-conditional reservation monitor for the CPU memory stage. Each of NUM_CH hardware channels holds its own LLbit, a reservation granule address and an optional expiry counter. The block grants or refuses SC requests and invalidates reservations on flush, on conflicting stores and on timeout. It sits beside the MEM/WB boundary and replaces a single-bit LLbit register.

---
 rtl/llsc_monitor_if.sv | 31 +++
 rtl/llsc_monitor.sv | 105 ++++++++++
 2 files changed

// File: rtl/llsc_monitor_if.sv
// Request/response bundle between the memory stage and the LL/SC reservation monitor.
// master drives the LL/SC/store commit strobes; slave returns the SC verdict and LLbits.
interface llsc_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] flush;
  logic              ll_we;
  logic [CH_W-1:0]   ll_ch;
  logic [ADDR_W-1:0] ll_addr;
  logic              sc_req;
  logic [CH_W-1:0]   sc_ch;
  logic [ADDR_W-1:0] sc_addr;
  logic              st_we;
  logic [CH_W-1:0]   st_ch;
  logic [ADDR_W-1:0] st_addr;
  logic              sc_ok;
  logic [NUM_CH-1:0] LLbit_o;

  modport master (
    output flush, ll_we, ll_ch, ll_addr, sc_req, sc_ch, sc_addr, st_we, st_ch, st_addr,
    input  sc_ok, LLbit_o
  );

  modport slave (
    input  flush, ll_we, ll_ch, ll_addr, sc_req, sc_ch, sc_addr, st_we, st_ch, st_addr,
    output sc_ok, LLbit_o
  );
endinterface

// File: rtl/llsc_monitor.sv
// Per-channel LL/SC reservation monitor: sc_ok is combinational from pre-edge state,
// every reservation update lands on the next edge; no backpressure, strobes always accepted.
module llsc_monitor #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int GRAN_BITS = 2,
  parameter int TIMEOUT   = 0
) (
  input logic           clk,
  input logic           rst,
  llsc_monitor_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int G_W   = ADDR_W - GRAN_BITS;

  typedef logic [G_W-1:0] gran_t;

  logic [NUM_CH-1:0] valid_q, valid_d;
  gran_t             resv_q [NUM_CH];
  gran_t             resv_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] kill;
  logic              sc_ok_c;
  logic              st_in;
  gran_t             ll_g, sc_g, st_g;

  assign ll_g  = bus.ll_addr[ADDR_W-1:GRAN_BITS];
  assign sc_g  = bus.sc_addr[ADDR_W-1:GRAN_BITS];
  assign st_g  = bus.st_addr[ADDR_W-1:GRAN_BITS];
  // Stores from a non-existent channel must not look like "another channel".
  assign st_in = ({1'b0, bus.st_ch} < (CH_W + 1)'(NUM_CH));

  generate
    if (GRAN_BITS > 0) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^{bus.ll_addr[GRAN_BITS-1:0], bus.sc_addr[GRAN_BITS-1:0],
                             bus.st_addr[GRAN_BITS-1:0]};
    end
  endgenerate

  always_comb begin
    sc_ok_c = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.sc_req && bus.sc_ch == CH_W'(c) && valid_q[c] && resv_q[c] == sc_g) begin
        sc_ok_c = 1'b1;
      end
    end
  end

  // Only a successful SC or a store from a different channel can steal a reservation.
  always_comb begin
    kill = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      kill[c] = valid_q[c] &&
                ((bus.st_we && st_in && bus.st_ch != CH_W'(c) && resv_q[c] == st_g) ||
                 (sc_ok_c && bus.sc_ch != CH_W'(c) && resv_q[c] == sc_g));
    end
  end

  always_comb begin
    valid_d = valid_q;
    resv_d  = resv_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.flush[c]) begin
        valid_d[c] = 1'b0;
        cnt_d[c]   = '0;
      end else if (bus.ll_we && bus.ll_ch == CH_W'(c)) begin
        valid_d[c] = 1'b1;
        resv_d[c]  = ll_g;
        cnt_d[c]   = '0;
      end else if (bus.sc_req && bus.sc_ch == CH_W'(c)) begin
        valid_d[c] = 1'b0;
      end else if (kill[c]) begin
        valid_d[c] = 1'b0;
      end else if (TIMEOUT != 0 && valid_q[c]) begin
        if (cnt_q[c] == CNT_W'(TIMEOUT - 1)) begin
          valid_d[c] = 1'b0;
          cnt_d[c]   = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        resv_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      resv_q  <= resv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sc_ok   = sc_ok_c;
  assign bus.LLbit_o = valid_q;
endmodule
